dest_hazard_unit: RTL and testbench
===================================

// Module: dest_hazard_unit
// PURPOSE
//  Consumer of the ID-stage destination register select: carries destReg and its write controls down the EX/MEM/WB
//  pipeline and compares each in-flight destination against the source registers of the instruction now in ID.
//  Generates ID-stage forwarding selects, the load-use stall, and the WB write-port address/enable for the register file.
//  Sits between the ID decode/destination mux and the register file in the 5-stage CPU.
// PARAMETERS
//  REG_W    5   register-number width (32 GPRs)
//  FWD_W    2   forwarding-select width
// PORTS
//  clk        in   1      rising-edge clock
//  resetn     in   1      asynchronous active-low reset
//  id_dest    in   5      destination register chosen in ID (rt or rd)
//  id_wreg    in   1      instruction in ID writes a register
//  id_m2reg   in   1      instruction in ID is a load (result comes from memory)
//  id_rs      in   5      source register rs of instruction in ID
//  id_rt      in   5      source register rt of instruction in ID
//  id_use_rs  in   1      ID instruction reads rs
//  id_use_rt  in   1      ID instruction reads rt
//  flush      in   1      squash the instruction entering EX (branch redirect)
//  stall      out  1      hold PC and IF/ID, insert bubble into EX
//  fwda       out  2      rs operand select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data
//  fwdb       out  2      rt operand select, same encoding
//  wb_dest    out  5      register-file write address
//  wb_wreg    out  1      register-file write enable
// BEHAVIOUR
//  - One clock, clk; resetn asynchronous, active low. Reset clears EX/MEM/WB dest, wreg, m2reg to 0.
//  - Reset values: stall=0, fwda=fwdb=00, wb_dest=0, wb_wreg=0 (outputs are pure functions of cleared state).
//  - Stage regs advance every rising edge: EX<=ID, MEM<=EX, WB<=MEM. No enable; pipeline never freezes past ID.
//  - Bubble: if stall or flush, EX loads wreg=0, m2reg=0, dest=0; ID values are dropped, not latched.
//  - Forward select (rs shown; rt identical with id_rt/id_use_rt -> fwdb), combinational, same cycle:
//      EX.wreg & EX.dest==rs & rs!=0 & !EX.m2reg      -> 01
//      else MEM.wreg & MEM.dest==rs & rs!=0            -> MEM.m2reg ? 11 : 10
//      else                                            -> 00
//    EX match has priority over MEM (youngest producer wins). Register 0 never forwards.
//    fwda=00 when id_use_rs=0; fwdb=00 when id_use_rt=0.
//  - Load-use stall: stall=1 iff EX.wreg & EX.m2reg & EX.dest!=0 & ((id_use_rs & EX.dest==id_rs) | (id_use_rt & EX.dest==id_rt)).
//    Exactly one stall cycle per load-use; next cycle the load is in MEM and the select resolves to 11.
//    During stall, fwda/fwdb are still driven but the consumer ignores them.
//  - flush and stall same cycle: bubble inserted once; stall still asserted to hold IF/ID.
//  - WB: wb_dest=WB.dest, wb_wreg=WB.wreg, registered, zero combinational logic. WB->ID handled by regfile write-first, no code here.
//  - Reset mid-operation: all in-flight writes discarded; wb_wreg falls to 0 asynchronously.
// STRUCTURE
//  - Shared package: REG_W, FWD_W, fwd codes FWD_RF=2'b00, FWD_EXE=2'b01, FWD_MEM=2'b10, FWD_MEMLD=2'b11;
//    stage record type {dest[4:0], wreg, m2reg}.
//  - One sub-module: dest_fwd_cmp (one source reg vs EX/MEM records -> 2-bit select + load hit), instantiated for rs and rt.
//  - Top: three stage registers, bubble mux, stall OR, WB output.
// TESTING
//  1 reset: resetn=0 with id_wreg=1 driven -> stall=0, fwda=fwdb=00, wb_wreg=0; release, 3 cycles later wb_wreg=1.
//  2 EX fwd: add $3 (dest 3,wreg) then sub using rs=3 next cycle -> fwda=01; following cycle rs=3 gives 10.
//  3 load-use: lw $5 (m2reg) then add rt=5 -> stall=1 one cycle, EX gets bubble, next cycle fwdb=11, stall=0.
//  4 priority/zero: two writers to $7 back-to-back then reader of $7 -> fwda=01; writer dest 0 then reader rs=0 -> fwda=00.
//  5 flush: flush=1 with id_wreg=1 dest 9 -> 3 cycles later wb_wreg=0; no forward from that slot at any stage.
//  6 async reset mid-flight: resetn low between edges with MEM holding a write -> wb_wreg, fwda drop to 0/00 without clock.

Source files
------------

// File: rtl/dest_hazard_unit_pkg.sv
// Shared types for the destination/hazard pipeline: register widths, forwarding
// select codes and the per-stage destination record.
package dest_hazard_unit_pkg;

  localparam int REG_W = 5;
  localparam int FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EXE   = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM   = 2'b10;
  localparam logic [FWD_W-1:0] FWD_MEMLD = 2'b11;

  typedef struct packed {
    logic [REG_W-1:0] dest;
    logic             wreg;
    logic             m2reg;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{dest: '0, wreg: 1'b0, m2reg: 1'b0};

endpackage

// File: rtl/dest_hazard_unit_fwd_cmp.sv
// Compares one ID source register against the EX and MEM destination records,
// producing its operand forwarding select and a load-use hit flag.
module dest_fwd_cmp
  import dest_hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  input  stage_t           ex_i,
  input  stage_t           mem_i,
  output logic [FWD_W-1:0] sel_o,
  output logic             load_hit_o
);

  logic ex_match;
  logic mem_match;

  assign ex_match  = ex_i.wreg  && (ex_i.dest  == src_i);
  assign mem_match = mem_i.wreg && (mem_i.dest == src_i);

  // A load in EX has no data yet, so it falls through to the MEM check (stall covers it).
  always_comb begin
    sel_o = FWD_RF;
    if (use_i && (src_i != '0)) begin
      if (ex_match && !ex_i.m2reg) begin
        sel_o = FWD_EXE;
      end else if (mem_match) begin
        sel_o = mem_i.m2reg ? FWD_MEMLD : FWD_MEM;
      end
    end
  end

  assign load_hit_o = use_i && ex_match && ex_i.m2reg && (ex_i.dest != '0);

endmodule

// File: rtl/dest_hazard_unit.sv
// Carries the ID destination down EX/MEM/WB, derives rs/rt forwarding selects,
// the load-use stall and the register-file write port.
module dest_hazard_unit
  import dest_hazard_unit_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             flush,
  output logic             stall,
  output logic [FWD_W-1:0] fwda,
  output logic [FWD_W-1:0] fwdb,
  output logic [REG_W-1:0] wb_dest,
  output logic             wb_wreg
);

  stage_t ex_q, mem_q, wb_q;
  stage_t ex_d;
  logic   hit_rs, hit_rt;

  dest_fwd_cmp u_cmp_rs (
    .src_i      (id_rs),
    .use_i      (id_use_rs),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .sel_o      (fwda),
    .load_hit_o (hit_rs)
  );

  dest_fwd_cmp u_cmp_rt (
    .src_i      (id_rt),
    .use_i      (id_use_rt),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .sel_o      (fwdb),
    .load_hit_o (hit_rt)
  );

  assign stall = hit_rs || hit_rt;

  // A stalled or squashed ID instruction never enters EX; a bubble takes its slot.
  always_comb begin
    ex_d = STAGE_BUBBLE;
    if (!stall && !flush) begin
      ex_d.dest  = id_dest;
      ex_d.wreg  = id_wreg;
      ex_d.m2reg = id_m2reg;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_q  <= STAGE_BUBBLE;
      mem_q <= STAGE_BUBBLE;
      wb_q  <= STAGE_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign wb_dest = wb_q.dest;
  assign wb_wreg = wb_q.wreg;

endmodule

// File: tb/tb_dest_hazard_unit.sv
// Directed scoreboard bench for dest_hazard_unit: stimulus pushes hand-computed
// expectations, a monitor pops and compares them at each sample point.
module tb_dest_hazard_unit;

  logic       clk;
  logic       resetn;
  logic [4:0] idDest;
  logic       idWreg;
  logic       idM2reg;
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic       idUseRs;
  logic       idUseRt;
  logic       flush;
  logic       stall;
  logic [1:0] fwda;
  logic [1:0] fwdb;
  logic [4:0] wbDest;
  logic       wbWreg;

  typedef struct {
    int         tag;
    logic       stall;
    logic [1:0] fwda;
    logic [1:0] fwdb;
    logic [4:0] wbDest;
    logic       wbWreg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event probeEv;

  dest_hazard_unit dut (
    .clk       (clk),
    .resetn    (resetn),
    .id_dest   (idDest),
    .id_wreg   (idWreg),
    .id_m2reg  (idM2reg),
    .id_rs     (idRs),
    .id_rt     (idRt),
    .id_use_rs (idUseRs),
    .id_use_rt (idUseRt),
    .flush     (flush),
    .stall     (stall),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .wb_dest   (wbDest),
    .wb_wreg   (wbWreg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input int tag, input string name,
                             input logic [4:0] actual, input logic [4:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL chk%0d %s: got %0d expected %0d", tag, name, actual, expected);
    end
  endtask

  // Waits one edge, then drives a complete ID-stage vector.
  task automatic applyStimulus(input logic [4:0] dest, input logic wreg, input logic m2reg,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic useRs, input logic useRt, input logic fl);
    @(posedge clk);
    #1;
    idDest  = dest;
    idWreg  = wreg;
    idM2reg = m2reg;
    idRs    = rs;
    idRt    = rt;
    idUseRs = useRs;
    idUseRt = useRt;
    flush   = fl;
  endtask

  task automatic pushExpect(input int tag, input logic st, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [4:0] wd, input logic ww);
    exp_t e;
    e.tag    = tag;
    e.stall  = st;
    e.fwda   = fa;
    e.fwdb   = fb;
    e.wbDest = wd;
    e.wbWreg = ww;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or probeEv);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e.tag, "stall",   {4'b0, stall},  {4'b0, e.stall});
        checkOutput(e.tag, "fwda",    {3'b0, fwda},   {3'b0, e.fwda});
        checkOutput(e.tag, "fwdb",    {3'b0, fwdb},   {3'b0, e.fwdb});
        checkOutput(e.tag, "wb_dest", wbDest,         e.wbDest);
        checkOutput(e.tag, "wb_wreg", {4'b0, wbWreg}, {4'b0, e.wbWreg});
      end
    end
  end

  initial begin : stimulus
    resetn = 1'b0;
    idDest = 5'd4; idWreg = 1'b1; idM2reg = 1'b0;
    idRs = '0; idRt = '0; idUseRs = 1'b0; idUseRt = 1'b0; flush = 1'b0;

    // Reset holds everything clear even with a writer in ID.
    applyStimulus(5'd4, 1, 0, 0, 0, 0, 0, 0);   pushExpect(0, 0, 2'b00, 2'b00, 5'd0, 0);
    applyStimulus(5'd4, 1, 0, 0, 0, 0, 0, 0);   resetn = 1'b1;
                                                pushExpect(1, 0, 2'b00, 2'b00, 5'd0, 0);
    applyStimulus(5'd0, 0, 0, 0, 0, 0, 0, 0);   pushExpect(2, 0, 2'b00, 2'b00, 5'd0, 0);
    applyStimulus(5'd0, 0, 0, 0, 0, 0, 0, 0);   pushExpect(3, 0, 2'b00, 2'b00, 5'd0, 0);
    // EX then MEM ALU forwarding.
    applyStimulus(5'd3, 1, 0, 1, 2, 1, 1, 0);   pushExpect(4, 0, 2'b00, 2'b00, 5'd4, 1);
    applyStimulus(5'd8, 1, 0, 3, 6, 1, 1, 0);   pushExpect(5, 0, 2'b01, 2'b00, 5'd0, 0);
    applyStimulus(5'd0, 0, 0, 3, 8, 1, 1, 0);   pushExpect(6, 0, 2'b10, 2'b01, 5'd0, 0);
    applyStimulus(5'd0, 0, 0, 0, 0, 0, 0, 0);   pushExpect(7, 0, 2'b00, 2'b00, 5'd3, 1);
    // Load-use: one stall, bubble, then MEM load data select.
    applyStimulus(5'd5, 1, 1, 2, 0, 1, 0, 0);   pushExpect(8, 0, 2'b00, 2'b00, 5'd8, 1);
    applyStimulus(5'd10, 1, 0, 1, 5, 1, 1, 0);  pushExpect(9, 1, 2'b00, 2'b00, 5'd0, 0);
    applyStimulus(5'd10, 1, 0, 1, 5, 1, 1, 0);  pushExpect(10, 0, 2'b00, 2'b11, 5'd0, 0);
    applyStimulus(5'd0, 0, 0, 0, 0, 0, 0, 0);   pushExpect(11, 0, 2'b00, 2'b00, 5'd5, 1);
    applyStimulus(5'd0, 0, 0, 0, 0, 0, 0, 0);   pushExpect(12, 0, 2'b00, 2'b00, 5'd0, 0);
    // Youngest producer wins; register 0 never forwards; unused rt gives 00.
    applyStimulus(5'd7, 1, 0, 0, 0, 0, 0, 0);   pushExpect(13, 0, 2'b00, 2'b00, 5'd10, 1);
    applyStimulus(5'd7, 1, 0, 0, 0, 0, 0, 0);   pushExpect(14, 0, 2'b00, 2'b00, 5'd0, 0);
    applyStimulus(5'd0, 0, 0, 7, 7, 1, 0, 0);   pushExpect(15, 0, 2'b01, 2'b00, 5'd0, 0);
    applyStimulus(5'd0, 1, 0, 0, 0, 0, 0, 0);   pushExpect(16, 0, 2'b00, 2'b00, 5'd7, 1);
    applyStimulus(5'd0, 0, 0, 0, 0, 1, 1, 0);   pushExpect(17, 0, 2'b00, 2'b00, 5'd7, 1);
    // Flushed writer to $9 never forwards nor writes back.
    applyStimulus(5'd9, 1, 0, 0, 0, 0, 0, 1);   pushExpect(18, 0, 2'b00, 2'b00, 5'd0, 0);
    applyStimulus(5'd0, 0, 0, 9, 9, 1, 1, 0);   pushExpect(19, 0, 2'b00, 2'b00, 5'd0, 1);
    applyStimulus(5'd0, 0, 0, 9, 9, 1, 1, 0);   pushExpect(20, 0, 2'b00, 2'b00, 5'd0, 0);
    applyStimulus(5'd12, 1, 1, 0, 0, 0, 0, 0);  pushExpect(21, 0, 2'b00, 2'b00, 5'd0, 0);
    // Flush together with load-use: stall still raised.
    applyStimulus(5'd13, 1, 0, 12, 0, 1, 0, 1); pushExpect(22, 1, 2'b00, 2'b00, 5'd0, 0);
    applyStimulus(5'd13, 1, 0, 12, 0, 1, 0, 0); pushExpect(23, 0, 2'b11, 2'b00, 5'd0, 0);
    applyStimulus(5'd14, 1, 0, 0, 0, 0, 0, 0);  pushExpect(24, 0, 2'b00, 2'b00, 5'd12, 1);
    applyStimulus(5'd16, 1, 0, 13, 14, 1, 1, 0); pushExpect(25, 0, 2'b10, 2'b01, 5'd0, 0);
    applyStimulus(5'd17, 1, 0, 16, 14, 1, 1, 0); pushExpect(26, 0, 2'b01, 2'b10, 5'd13, 1);
    applyStimulus(5'd0, 0, 0, 16, 0, 1, 0, 0);  pushExpect(27, 0, 2'b10, 2'b00, 5'd14, 1);
    // Asynchronous reset between edges with MEM and WB holding writes.
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    pushExpect(28, 0, 2'b00, 2'b00, 5'd0, 0);
    ->probeEv;
    applyStimulus(5'd0, 0, 0, 16, 0, 1, 0, 0);  pushExpect(29, 0, 2'b00, 2'b00, 5'd0, 0);
    resetn = 1'b1;
    applyStimulus(5'd0, 0, 0, 0, 0, 0, 0, 0);   pushExpect(30, 0, 2'b00, 2'b00, 5'd0, 0);
    repeat (3) @(posedge clk);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
